// File: rtl/count_monitor_if.sv
// count_monitor_if: groups the monitored count bus and the monitor's status outputs.
// Ports: en/clr/count flow from the counter side to the monitor; locked/tc/err/err_cnt/wrap_cnt flow back.
// master drives the sample inputs and observes status; slave is the monitor itself.
interface count_monitor_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] count;
  logic             locked;
  logic             tc;
  logic             err;
  logic [7:0]       err_cnt;
  logic [7:0]       wrap_cnt;

  modport master (
    output en, clr, count,
    input  locked, tc, err, err_cnt, wrap_cnt
  );

  modport slave (
    input  en, clr, count,
    output locked, tc, err, err_cnt, wrap_cnt
  );
endinterface

// File: rtl/count_monitor.sv
// count_monitor: locks onto a +1 mod 2^WIDTH count sequence, then flags illegal transitions.
// Latency: one cycle from the sampled count to every registered output.
// Backpressure: none; a sample is taken on every cycle with en=1, all state holds when en=0.
//
// Ports: clk, rst (async, active-low), mon (count_monitor_if.slave: en, clr, count in;
//        locked, tc, err, err_cnt, wrap_cnt out).
// Build option: define COUNT_MON_HOLD_EN to treat count == prev as a legal hold
//               (no progress, no error) instead of a mismatch.
module count_monitor #(
  parameter int WIDTH  = 3,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  count_monitor_if.slave   mon
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] prev,  prev_n;
  logic [3:0]       good,  good_n;
  logic             tc_n;
  logic             err_ev;
  logic             wrap_ev;

  logic [WIDTH-1:0] prev_inc;
  logic             legal;
  logic             hold;
  logic             lock_hit;

  assign prev_inc = prev + WIDTH'(1);
  assign legal    = (mon.count == prev_inc);

`ifdef COUNT_MON_HOLD_EN
  assign hold = (mon.count == prev);
`else
  assign hold = 1'b0;
`endif

  // Widen before the increment so LOCK_N = 15 compares cleanly.
  assign lock_hit = (({1'b0, good} + 5'd1) == 5'(LOCK_N));

  // Next-state and event decode.
  always_comb begin
    state_n = state;
    prev_n  = prev;
    good_n  = good;
    tc_n    = 1'b0;
    err_ev  = 1'b0;
    wrap_ev = 1'b0;

    if (mon.en) begin
      // Always resynchronise to the sampled value, including after a mismatch.
      prev_n = mon.count;
      unique case (state)
        IDLE: begin
          good_n  = 4'd0;
          state_n = LOCK;
        end
        LOCK: begin
          // A max->0 wrap here only advances good; tc is reserved for TRACK.
          if (legal) begin
            good_n = good + 4'd1;
            if (lock_hit) begin
              state_n = TRACK;
            end
          end else if (!hold) begin
            good_n = 4'd0;
          end
        end
        TRACK: begin
          if (legal) begin
            if (prev == {WIDTH{1'b1}}) begin
              tc_n    = 1'b1;
              wrap_ev = 1'b1;
            end
          end else if (!hold) begin
            err_ev  = 1'b1;
            good_n  = 4'd0;
            state_n = LOCK;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // FSM, sample history and the tc / locked output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prev       <= '0;
      good       <= 4'd0;
      mon.tc     <= 1'b0;
      mon.locked <= 1'b0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      good       <= good_n;
      mon.tc     <= tc_n;
      mon.locked <= (state_n == TRACK);
    end
  end

  // Status tallies. clr wins over a same-cycle event, so that event is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mon.err      <= 1'b0;
      mon.err_cnt  <= 8'd0;
      mon.wrap_cnt <= 8'd0;
    end else if (mon.clr) begin
      mon.err      <= 1'b0;
      mon.err_cnt  <= 8'd0;
      mon.wrap_cnt <= 8'd0;
    end else begin
      if (err_ev) begin
        mon.err <= 1'b1;
        if (mon.err_cnt != 8'hFF) begin
          mon.err_cnt <= mon.err_cnt + 8'd1;
        end
      end
      if (wrap_ev && (mon.wrap_cnt != 8'hFF)) begin
        mon.wrap_cnt <= mon.wrap_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: scoreboard bench for count_monitor (WIDTH=3, LOCK_N=4).
// Each driven cycle pushes the reference model's expected outputs; they are popped
// and compared one cycle later, plus directed checks at the scenario milestones.
module tb_count_monitor;

  localparam int WIDTH  = 3;
  localparam int LOCK_N = 4;

  logic clk;
  logic rst;

  count_monitor_if #(.WIDTH(WIDTH)) bus ();

  count_monitor #(
    .WIDTH (WIDTH),
    .LOCK_N(LOCK_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       locked;
    logic       tc;
    logic       err;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: 0 = idle, 1 = acquiring lock, 2 = tracking.
  int         m_mode;
  logic [2:0] m_prev;
  int         m_run;
  logic       m_tc;
  logic       m_err;
  int         m_ec;
  int         m_wc;

  logic [2:0] cur;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_prev = 3'd0;
    m_run  = 0;
    m_tc   = 1'b0;
    m_err  = 1'b0;
    m_ec   = 0;
    m_wc   = 0;
  endtask

  task automatic model_step(input logic e, input logic c, input logic [2:0] v);
    logic next_ok;
    logic same;
    logic saw_err;
    logic saw_wrap;
    next_ok  = (v == ((m_prev + 3'd1) & 3'd7));
`ifdef COUNT_MON_HOLD_EN
    same     = (v == m_prev);
`else
    same     = 1'b0;
`endif
    saw_err  = 1'b0;
    saw_wrap = 1'b0;
    m_tc     = 1'b0;
    if (e) begin
      if (m_mode == 0) begin
        m_run  = 0;
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (next_ok) begin
          m_run = m_run + 1;
          if (m_run == LOCK_N) m_mode = 2;
        end else if (!same) begin
          m_run = 0;
        end
      end else begin
        if (next_ok) begin
          if (m_prev == 3'd7) begin
            m_tc     = 1'b1;
            saw_wrap = 1'b1;
          end
        end else if (!same) begin
          saw_err = 1'b1;
          m_run   = 0;
          m_mode  = 1;
        end
      end
      m_prev = v;
    end
    if (c) begin
      m_err = 1'b0;
      m_ec  = 0;
      m_wc  = 0;
    end else begin
      if (saw_err) begin
        m_err = 1'b1;
        if (m_ec < 255) m_ec = m_ec + 1;
      end
      if (saw_wrap && m_wc < 255) m_wc = m_wc + 1;
    end
  endtask

  // One clock: drive at negedge, predict, then compare just after the rising edge.
  task automatic cyc(input logic e, input logic c, input logic [2:0] v);
    exp_t x;
    exp_t y;
    @(negedge clk);
    bus.en    = e;
    bus.clr   = c;
    bus.count = v;
    model_step(e, c, v);
    x.locked   = (m_mode == 2);
    x.tc       = m_tc;
    x.err      = m_err;
    x.err_cnt  = 8'(m_ec);
    x.wrap_cnt = 8'(m_wc);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    y = exp_q.pop_front();
    chk("sb_locked",   32'(bus.locked),   32'(y.locked));
    chk("sb_tc",       32'(bus.tc),       32'(y.tc));
    chk("sb_err",      32'(bus.err),      32'(y.err));
    chk("sb_err_cnt",  32'(bus.err_cnt),  32'(y.err_cnt));
    chk("sb_wrap_cnt", 32'(bus.wrap_cnt), 32'(y.wrap_cnt));
  endtask

  // Four legal increments from cur: enough to go from a fresh mismatch to TRACK.
  task automatic legal4();
    for (int k = 0; k < 4; k++) begin
      cur = cur + 3'd1;
      cyc(1'b1, 1'b0, cur);
    end
  endtask

  task automatic one_error();
    legal4();
    cur = cur + 3'd3;
    cyc(1'b1, 1'b0, cur);
  endtask

  initial begin
    rst       = 1'b0;
    bus.en    = 1'b0;
    bus.clr   = 1'b0;
    bus.count = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked",   32'(bus.locked),   32'd0);
    chk("rst_tc",       32'(bus.tc),       32'd0);
    chk("rst_err",      32'(bus.err),      32'd0);
    chk("rst_err_cnt",  32'(bus.err_cnt),  32'd0);
    chk("rst_wrap_cnt", 32'(bus.wrap_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Acquire lock on 0..4.
    for (int i = 0; i <= 4; i++) begin
      cyc(1'b1, 1'b0, 3'(i));
      if (i == 3) chk("not_yet_locked", 32'(bus.locked), 32'd0);
    end
    chk("lock_up", 32'(bus.locked), 32'd1);
    chk("lock_err", 32'(bus.err), 32'd0);

    // Wrap while tracking: 5,6,7,0,1.
    cyc(1'b1, 1'b0, 3'd5);
    cyc(1'b1, 1'b0, 3'd6);
    cyc(1'b1, 1'b0, 3'd7);
    cyc(1'b1, 1'b0, 3'd0);
    chk("wrap_tc", 32'(bus.tc), 32'd1);
    cyc(1'b1, 1'b0, 3'd1);
    chk("wrap_tc_gone", 32'(bus.tc), 32'd0);
    chk("wrap_cnt_1", 32'(bus.wrap_cnt), 32'd1);

    // Mismatch at prev=2, then relock through a wrap seen in LOCK.
    cyc(1'b1, 1'b0, 3'd2);
    cyc(1'b1, 1'b0, 3'd5);
    chk("mm_err", 32'(bus.err), 32'd1);
    chk("mm_err_cnt", 32'(bus.err_cnt), 32'd1);
    chk("mm_unlock", 32'(bus.locked), 32'd0);
    cyc(1'b1, 1'b0, 3'd6);
    cyc(1'b1, 1'b0, 3'd7);
    cyc(1'b1, 1'b0, 3'd0);
    chk("lock_wrap_no_tc", 32'(bus.tc), 32'd0);
    cyc(1'b1, 1'b0, 3'd1);
    chk("relock", 32'(bus.locked), 32'd1);
    chk("err_sticky", 32'(bus.err), 32'd1);

    // Hold at 3 for two samples (tallies cleared first).
    cyc(1'b1, 1'b1, 3'd2);
    cyc(1'b1, 1'b0, 3'd3);
    cyc(1'b1, 1'b0, 3'd3);
`ifdef COUNT_MON_HOLD_EN
    chk("hold_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("hold_locked", 32'(bus.locked), 32'd1);
`else
    chk("hold_err_cnt", 32'(bus.err_cnt), 32'd1);
    chk("hold_locked", 32'(bus.locked), 32'd0);
`endif
    for (int i = 4; i <= 7; i++) cyc(1'b1, 1'b0, 3'(i));

    // Mismatch with clr in the same cycle: event dropped, lock still lost.
    cyc(1'b1, 1'b1, 3'd1);
    chk("clr_err", 32'(bus.err), 32'd0);
    chk("clr_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("clr_locked", 32'(bus.locked), 32'd0);
    cur = 3'd1;

    // 300 errors in TRACK: err_cnt saturates.
    for (int n = 0; n < 300; n++) one_error();
    chk("sat_err_cnt", 32'(bus.err_cnt), 32'd255);

    // Build err_cnt=7 in TRACK, then reset asynchronously mid-cycle.
    cyc(1'b0, 1'b1, cur);
    for (int n = 0; n < 7; n++) one_error();
    legal4();
    chk("pre_rst_err_cnt", 32'(bus.err_cnt), 32'd7);
    chk("pre_rst_locked", 32'(bus.locked), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_locked",   32'(bus.locked),   32'd0);
    chk("arst_tc",       32'(bus.tc),       32'd0);
    chk("arst_err",      32'(bus.err),      32'd0);
    chk("arst_err_cnt",  32'(bus.err_cnt),  32'd0);
    chk("arst_wrap_cnt", 32'(bus.wrap_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Re-enter via IDLE, lock, create one error, relock, clr with en=0.
    cur = 3'd6;
    cyc(1'b1, 1'b0, cur);
    one_error();
    legal4();
    cyc(1'b0, 1'b1, 3'(cur + 3'd5));
    chk("en0_clr", 32'(bus.err_cnt), 32'd0);

    // en=0 with a wandering count: nothing moves, and the sequence resumes from prev.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 3'($urandom_range(0, 7)));
    chk("en0_locked", 32'(bus.locked), 32'd1);
    cur = cur + 3'd1;
    cyc(1'b1, 1'b0, cur);
    chk("resume_locked", 32'(bus.locked), 32'd1);
    chk("resume_err", 32'(bus.err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
# count_monitor

Downstream checker for the 3-bit up-counter stage. Samples the counter's `count` bus each enabled cycle, locks onto a legal increment sequence, and then flags any illegal transition. Also emits a terminal-count pulse and keeps saturating wrap and error tallies for status/debug logic further down the datapath.

## Interface
- `WIDTH`, 3: width of the monitored count bus; legal sequence is +1 modulo 2^WIDTH.
- `LOCK_N`, 4: consecutive legal transitions required to declare lock; legal range 1..15.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `en`  input  1  sample qualifier; `count` is ignored and all state holds when low.
- `clr`  input  1  synchronous clear of `err`, `err_cnt`, `wrap_cnt`.
- `count`  input  WIDTH  counter value from the upstream up-counter.
- `locked`  output  1  high while in TRACK.
- `tc`  output  1  one-cycle pulse on a legal max→0 transition seen in TRACK.
- `err`  output  1  sticky illegal-transition flag.
- `err_cnt`  output  8  saturating count of illegal transitions.
- `wrap_cnt`  output  8  saturating count of `tc` events.

## Operation
- Internal registers: `prev` (WIDTH), `good` (4 bits), FSM state.
- Legal transition: `count == prev + 1` (mod 2^WIDTH). Anything else is a mismatch.
- FSM, evaluated only on cycles with `en=1`:
  - IDLE: reset state. On first enabled cycle: `prev<=count`, `good<=0`, go to LOCK.
  - LOCK: legal → `good<=good+1`; when `good+1 == LOCK_N`, go to TRACK. Mismatch → `good<=0`, stay in LOCK. No error reporting in LOCK.
  - TRACK: legal → stay. If legal and `prev == 2^WIDTH-1`, pulse `tc` and `wrap_cnt<=wrap_cnt+1` (saturates at 255). Mismatch → `err<=1`, `err_cnt<=err_cnt+1` (saturates at 255), `good<=0`, go to LOCK.
  - Every enabled cycle in any state ends with `prev<=count`; this resynchronises to the new value after a mismatch.
- `clr=1` has priority over a same-cycle increment: `err`, `err_cnt` and `wrap_cnt` go to 0, and the concurrent error or wrap event is not recorded. `tc` still pulses. The FSM and `prev` are unaffected by `clr`.
- `en=0`: no state changes, `tc=0`, `clr` still honoured.

## Timing
- Reset values: state=IDLE, `prev=0`, `good=0`, `locked=0`, `tc=0`, `err=0`, `err_cnt=0`, `wrap_cnt=0`.
- All outputs are registered. Latency is one cycle from the sampled `count` edge to the output update.
- `locked` rises in the cycle after the LOCK_N-th consecutive legal sample. It falls in the cycle after the first mismatch.
- `tc` is high for exactly one cycle per wrap, and never in IDLE or LOCK.
- Reset asserted mid-operation returns everything to its reset values immediately (asynchronously). The first sample after reset release re-enters LOCK.
- A wrap counted as legal in LOCK (max→0) advances `good` only. It does not produce `tc`.

## Configuration
- `COUNT_MON_HOLD_EN`:
  - Defined: `count == prev` is a legal hold. It does not advance `good`, does not reset `good`, and raises no error. State is unchanged.
  - Undefined: a hold is a mismatch, like any other illegal value.

## Test plan
- Reset, then `en=1` with `count` = 0,1,2,3,4 on consecutive cycles (LOCK_N=4) → `locked` goes to 1 on the cycle after `count=4` is sampled; `err=0`.
- Locked, `count` runs 5,6,7,0,1 → `tc`=1 for exactly the cycle after 0 is sampled; `wrap_cnt=1`; `err=0`.
- Locked at `prev=2`, drive `count=5` → next cycle `err=1`, `err_cnt=1`, `locked=0`. Then 6,7,0,1 → `locked=1` again; `err` stays 1.
- `count` held at 3 for two enabled cycles while locked → with macro defined: no error, `locked=1`. Without macro: `err_cnt=1`, `locked=0`.
- Mismatch and `clr=1` in the same cycle → `err=0`, `err_cnt=0`, `locked=0`. Drive 300 mismatches → `err_cnt` holds at 255.
- Assert `rst` low mid-TRACK with `err_cnt=7` → all outputs 0 immediately. `en=0` cycles with changing `count` → no state or output change.
